// File: rtl/noc_link_retimer.sv
// Router-to-router link retimer: NUM_PIPELINE register stages on the forward flit path and the
// reverse credit path, plus a saturating flits-in-flight counter. Optional checker: NOC_LINK_CREDIT_CHECK_EN.
module noc_link_retimer #(
  parameter int NUM_PIPELINE      = 1,
  parameter int FLIT_WIDTH        = 32,
  parameter int DEST_WIDTH        = 6,
  parameter int FLIT_BUFFER_DEPTH = 256,
  parameter int CNT_WIDTH         = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
  input  logic                  clk_noc,
  input  logic                  rst_n,
  input  logic [FLIT_WIDTH-1:0] data_in,
  input  logic [DEST_WIDTH-1:0] dest_in,
  input  logic                  is_tail_in,
  input  logic                  send_in,
  output logic                  credit_out,
  output logic [FLIT_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0] dest_out,
  output logic                  is_tail_out,
  output logic                  send_out,
  input  logic                  credit_in,
  output logic [CNT_WIDTH-1:0]  outstanding,
  output logic                  err_credit
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FLIT_BUFFER_DEPTH);

  if (NUM_PIPELINE == 0) begin : g_bypass
    assign data_out    = data_in;
    assign dest_out    = dest_in;
    assign is_tail_out = is_tail_in;
    assign send_out    = send_in;
    assign credit_out  = credit_in;
  end else begin : g_pipe
    logic [NUM_PIPELINE-1:0] send_q;
    logic [NUM_PIPELINE-1:0] credit_q;
    logic [NUM_PIPELINE-1:0] tail_q;
    logic [FLIT_WIDTH-1:0]   data_q [NUM_PIPELINE];
    logic [DEST_WIDTH-1:0]   dest_q [NUM_PIPELINE];

    always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
        send_q   <= '0;
        credit_q <= '0;
        tail_q   <= '0;
        // NOTE: payload stages are cleared too so data_out is deterministic straight out of reset.
        for (int i = 0; i < NUM_PIPELINE; i++) begin
          data_q[i] <= '0;
          dest_q[i] <= '0;
        end
      end else begin
        send_q[0]   <= send_in;
        credit_q[0] <= credit_in;
        if (send_in) begin
          data_q[0] <= data_in;
          dest_q[0] <= dest_in;
          tail_q[0] <= is_tail_in;
        end
        for (int i = 1; i < NUM_PIPELINE; i++) begin
          send_q[i]   <= send_q[i-1];
          credit_q[i] <= credit_q[i-1];
          // Payload only moves alongside a valid flit; idle cycles leave it parked.
          if (send_q[i-1]) begin
            data_q[i] <= data_q[i-1];
            dest_q[i] <= dest_q[i-1];
            tail_q[i] <= tail_q[i-1];
          end
        end
      end
    end

    assign data_out    = data_q[NUM_PIPELINE-1];
    assign dest_out    = dest_q[NUM_PIPELINE-1];
    assign is_tail_out = tail_q[NUM_PIPELINE-1];
    assign send_out    = send_q[NUM_PIPELINE-1];
    assign credit_out  = credit_q[NUM_PIPELINE-1];
  end

  // Upstream-side view: flits launched minus credits handed back, clamped at both ends.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else if (send_in && !credit_out) begin
      if (outstanding != CNT_MAX) outstanding <= outstanding + 1'b1;
    end else if (credit_out && !send_in) begin
      if (outstanding != '0) outstanding <= outstanding - 1'b1;
    end
  end

`ifdef NOC_LINK_CREDIT_CHECK_EN
  typedef enum logic {IDLE, IN_PKT} pkt_state_e;

  pkt_state_e            state;
  logic [DEST_WIDTH-1:0] head_dest;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      head_dest  <= '0;
      err_credit <= 1'b0;
    end else begin
      if (send_in) begin
        case (state)
          IDLE: if (!is_tail_in) begin
            state     <= IN_PKT;
            head_dest <= dest_in;
          end
          IN_PKT: if (is_tail_in) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
      if ((send_in && outstanding == CNT_MAX) ||
          (credit_out && outstanding == '0) ||
          (state == IN_PKT && send_in && dest_in != head_dest))
        err_credit <= 1'b1;
    end
  end
`else
  assign err_credit = 1'b0;
`endif

endmodule

// File: tb/tb_noc_link_retimer.sv
// Scoreboard bench for noc_link_retimer: a 2-stage link with credit checks, plus a 0-stage
// passthrough instance sharing the same stimulus.
module tb_noc_link_retimer;

  localparam int NP    = 2;
  localparam int DEPTH = 256;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef NOC_LINK_CREDIT_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic        tail;
    int          cyc;
  } flit_t;

  logic          clk_noc = 1'b0;
  logic          rst_n;
  logic [31:0]   data_in;
  logic [5:0]    dest_in;
  logic          is_tail_in, send_in, credit_in;
  logic          credit_out, is_tail_out, send_out, err_credit;
  logic [31:0]   data_out;
  logic [5:0]    dest_out;
  logic [CW-1:0] outstanding;

  logic          p0_credit_out, p0_is_tail_out, p0_send_out, p0_err_credit;
  logic [31:0]   p0_data_out;
  logic [5:0]    p0_dest_out;
  logic [CW-1:0] p0_outstanding;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_out = 0;
  flit_t flit_q[$];
  int    cred_q[$];

  always #5 clk_noc = ~clk_noc;
  always @(posedge clk_noc) cyc++;

  noc_link_retimer #(.NUM_PIPELINE(NP), .FLIT_BUFFER_DEPTH(DEPTH)) dut (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(credit_out),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .outstanding(outstanding),
    .err_credit(err_credit)
  );

  noc_link_retimer #(.NUM_PIPELINE(0), .FLIT_BUFFER_DEPTH(DEPTH)) dut_p0 (
    .clk_noc(clk_noc), .rst_n(rst_n), .data_in(data_in), .dest_in(dest_in),
    .is_tail_in(is_tail_in), .send_in(send_in), .credit_out(p0_credit_out),
    .data_out(p0_data_out), .dest_out(p0_dest_out), .is_tail_out(p0_is_tail_out),
    .send_out(p0_send_out), .credit_in(credit_in), .outstanding(p0_outstanding),
    .err_credit(p0_err_credit)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drive one cycle of stimulus starting at posedge+1 and log what must come out.
  task automatic drive(input logic s, input logic [31:0] d, input logic [5:0] de,
                       input logic t, input logic c);
    flit_t f;
    send_in = s; data_in = d; dest_in = de; is_tail_in = t; credit_in = c;
    if (s) begin
      f.data = d; f.dest = de; f.tail = t; f.cyc = cyc + NP;
      flit_q.push_back(f);
    end
    if (c) cred_q.push_back(cyc + NP);
    @(posedge clk_noc); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    flit_q.delete();
    cred_q.delete();
    exp_out = 0;
    @(posedge clk_noc); #1;
    rst_n = 1'b1;
  endtask

  // Output monitor, sampled mid-cycle on the falling edge.
  always @(negedge clk_noc) begin
    if (rst_n === 1'b1) begin
      if (send_out) begin
        if (flit_q.size() == 0) check("flit_spurious", 1, 0);
        else begin
          flit_t f;
          f = flit_q.pop_front();
          check("flit_fields", {data_out, dest_out, is_tail_out}, {f.data, f.dest, f.tail});
          check("flit_cycle", cyc, f.cyc);
        end
      end
      if (credit_out) begin
        if (cred_q.size() == 0) check("credit_spurious", 1, 0);
        else check("credit_cycle", cyc, cred_q.pop_front());
      end
      check("outstanding", outstanding, exp_out);
      if (send_in && !credit_out && exp_out != DEPTH) exp_out++;
      else if (credit_out && !send_in && exp_out != 0) exp_out--;
      check("p0_passthrough",
            {p0_send_out, p0_data_out, p0_dest_out, p0_is_tail_out, p0_credit_out},
            {send_in, data_in, dest_in, is_tail_in, credit_in});
    end
  end

  initial begin
    rst_n = 1'b0;
    send_in = 1'b0; data_in = '0; dest_in = '0; is_tail_in = 1'b0; credit_in = 1'b0;
    repeat (3) @(posedge clk_noc);
    #1;
    check("rst_send_out", send_out, 0);
    check("rst_credit_out", credit_out, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_err", err_credit, 0);
    rst_n = 1'b1;
    idle(2);

    // Single tail flit, then hand its credit back.
    drive(1'b1, 32'hA5A5A5A5, 6'h13, 1'b1, 1'b0);
    idle(3);
    check("t1_outstanding", outstanding, 1);
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
    idle(4);
    check("t1_drained", outstanding, 0);

    // Fill the full credit budget, then overrun by one flit.
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i == DEPTH) check("t2_full", outstanding, DEPTH);
      drive(1'b1, 32'h0101_0101 * i + 32'h5A, 6'(i), 1'(i % 4 == 3), 1'b0);
    end
    check("t2_saturated", outstanding, DEPTH);
    check("t2_overflow_err", err_credit, EXP_ERR);
    idle(4);
    pulse_reset();
    idle(1);

    // Ten flits out, four back-to-back credits back.
    for (int i = 0; i < 10; i++) drive(1'b1, 32'hC0DE_0000 + i, 6'h2A, 1'b1, 1'b0);
    idle(3);
    check("t3_ten", outstanding, 10);
    for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
    idle(5);
    check("t3_six", outstanding, 6);
    drive(1'b0, 32'h0, 6'h0, 1'b0, 1'b1);
    idle(1);
    drive(1'b1, 32'h1234_5678, 6'h01, 1'b1, 1'b0);
    check("t3_simultaneous", outstanding, 6);
    idle(4);
    check("t3_no_err", err_credit, 0);

    // Body flit addressed away from the head's destination.
    drive(1'b1, 32'h1111_0001, 6'h05, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_0002, 6'h05, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_0003, 6'h09, 1'b0, 1'b0);
    drive(1'b1, 32'h1111_0004, 6'h05, 1'b1, 1'b0);
    idle(4);
    check("t5_dest_err", err_credit, EXP_ERR);

    // Reset with two flits and one credit in flight.
    drive(1'b1, 32'hDEAD_0001, 6'h11, 1'b0, 1'b0);
    drive(1'b1, 32'hDEAD_0002, 6'h11, 1'b1, 1'b1);
    send_in = 1'b0; credit_in = 1'b0;
    check("t6_pre_send", send_out, 1);
    #1;
    rst_n = 1'b0;
    flit_q.delete();
    cred_q.delete();
    exp_out = 0;
    #1;
    check("t6_send_out", send_out, 0);
    check("t6_credit_out", credit_out, 0);
    check("t6_outstanding", outstanding, 0);
    check("t6_err", err_credit, 0);
    @(posedge clk_noc); #1;
    rst_n = 1'b1;
    idle(6);

    // Random traffic on both instances.
    for (int i = 0; i < 1000; i++)
      drive(1'($urandom_range(0, 1)), $urandom, 6'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
    idle(6);
    check("flit_q_empty", flit_q.size(), 0);
    check("cred_q_empty", cred_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
